imem_bus_responder: RTL and testbench
=====================================

IMEM_BUS_RESPONDER -- requirements
Module: imem_bus_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, backing store size in bytes (power of two, at least 16).
REQ-002 SHALL have parameter LATENCY, default 3, cycles from request accept to first response beat (at least 1).
REQ-003 SHALL have port CLK input 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET input 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid input 1: request present.
REQ-006 SHALL have port req_ready output 1: responder can accept a request.
REQ-007 SHALL have port req_addr input 64: byte address.
REQ-008 SHALL have port req_we input 1: 1 = word write, 0 = line read.
REQ-009 SHALL have port req_wdata input 32: write data, little-endian.
REQ-010 SHALL have port req_wstrb input 4: byte enables; bit i writes byte i.
REQ-011 SHALL have port rsp_valid output 1: response beat present.
REQ-012 SHALL have port rsp_ready input 1: requester accepts the beat.
REQ-013 SHALL have port rsp_data output 32: read word, little-endian.
REQ-014 SHALL have port rsp_last output 1: final beat of the response.
REQ-015 SHALL have port rsp_err output 1: address out of range.

Function
REQ-016 SHALL use FSM states IDLE, WAIT, BURST and WRESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on the cycle when req_valid and req_ready are both 1, capturing addr, we, wdata and wstrb.
REQ-018 Out of range: when any req_addr bit at or above log2(MEM_BYTES) is 1, SHALL return one beat with rsp_err=1, rsp_last=1, rsp_data=0 after LATENCY, and SHALL NOT modify memory.
REQ-019 Read: SHALL go IDLE to WAIT and count LATENCY-1 cycles, then enter BURST; first rsp_valid appears exactly LATENCY cycles after the accept edge.
REQ-020 Read burst: SHALL send 4 beats covering the aligned 16-byte line, critical word first.
- Beat k carries the word at index (addr[3:2]+k) mod 4, wrapping within the line.
- Beat 3 has rsp_last=1.
REQ-021 Stall: while rsp_valid=1 and rsp_ready=0, SHALL hold rsp_data, rsp_last, rsp_err and the beat index stable; it advances only on a handshake.
REQ-022 Write: SHALL update the bytes of word addr[log2(MEM_BYTES)-1:2] selected by wstrb on the accept edge, go to WRESP, and present one beat next cycle (rsp_data=0, rsp_last=1, rsp_err=0). addr[1:0] SHALL be ignored.
REQ-023 wstrb=0 SHALL leave memory unchanged and still produce the WRESP beat.
REQ-024 After the handshake of the rsp_last beat, SHALL return to IDLE; req_ready=1 the following cycle. No back-to-back accept on the same edge.
REQ-025 A read issued after a write completes SHALL observe the written data.
REQ-026 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-027 RESET SHALL force IDLE, with req_ready=1, rsp_valid=0, rsp_last=0, rsp_err=0, rsp_data=0, and clear the latency counter and beat index.
REQ-028 RESET asserted mid-WAIT or mid-BURST SHALL abort the transaction with no further beats; rsp_valid=0 the next cycle.
REQ-029 RESET SHALL NOT alter memory contents.

Structure
REQ-030 Package imem_bus_pkg SHALL hold the FSM state enum, BEATS_PER_LINE=4, WORD_BYTES=4 and LINE_BYTES=16.
REQ-031 Storage SHALL be the sub-module imem_byte_array: byte array with a 4-strobe word write and a combinational word read.
REQ-032 The read index SHALL be registered in the responder so rsp_data comes from a registered index.

Verification
REQ-033 Write 0x00508093 at 0x0 with wstrb=0xF, then read 0x0 -> WRESP beat after 1 cycle; read beats 0x00508093, w1, w2, w3, first at +3 cycles, last on beat 4.
REQ-034 Read 0x8 -> beats word2, word3, word0, word1 (wrap-around); rsp_last on the 4th.
REQ-035 Hold rsp_ready=0 for 5 cycles on beat 2 -> rsp_data stable; beats 3–4 follow after release with no loss or duplication.
REQ-036 Read 0x400 with MEM_BYTES=1024 -> single beat with rsp_err=1, rsp_last=1, data 0; memory unchanged.
REQ-037 Write wstrb=0x2 data 0xAABBCCDD to 0x4 over 0x11223344 -> read-back word 0x1122CC44.
REQ-038 Assert RESET during beat 2 of a read -> rsp_valid=0 next cycle; req_ready=1; a new read returns correct data.

Source files
------------

// File: rtl/imem_bus_pkg.sv
// Shared types and line geometry for the instruction-memory bus responder.
package imem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WRESP
    } state_t;

    localparam int BEATS_PER_LINE = 4;
    localparam int WORD_BYTES     = 4;
    localparam int LINE_BYTES     = 16;

endpackage

// File: rtl/imem_byte_array.sv
// Byte-addressed backing store: one 4-strobe word write port and one
// combinational little-endian word read port.
module imem_byte_array
    import imem_bus_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int IDX_W     = 8
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [7:0] mem [MEM_BYTES];

    // write only the byte lanes selected by the strobes
    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (wstrb[i]) mem[{widx, 2'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

    // assemble the word at the read index, byte 0 in the low lane
    always_comb begin
        rdata = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rdata[8*i +: 8] = mem[{ridx, 2'(i)}];
        end
    end

endmodule

// File: rtl/imem_bus_responder.sv
// Instruction-memory bus responder: single-word strobed writes answered with
// one beat, line reads answered with a 4-beat critical-word-first burst after
// a fixed latency, and out-of-range accesses answered with one error beat.
module imem_bus_responder
    import imem_bus_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err
);

    localparam int AW     = $clog2(MEM_BYTES);
    localparam int IW     = AW - 2;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam int BEAT_W = $clog2(BEATS_PER_LINE);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  lat_cnt;
    logic [BEAT_W-1:0] beat;
    logic              err_q;
    logic [IW-1:0]     rd_idx;
    logic [31:0]       mem_rdata;
    logic              accept;
    logic              addr_oor;
    logic              mem_we;
    logic              unused_addr_lsb;

    // byte offset within a word never selects anything
    assign unused_addr_lsb = ^req_addr[1:0];

    assign addr_oor = |req_addr[63:AW];
    assign accept   = req_valid && req_ready;
    // in-range writes commit on the accept edge; out-of-range ones never touch memory
    assign mem_we   = accept && req_we && !addr_oor;

    imem_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .IDX_W     (IW)
    ) u_array (
        .CLK   (CLK),
        .we    (mem_we),
        .widx  (req_addr[AW-1:2]),
        .wdata (req_wdata),
        .wstrb (req_wstrb),
        .ridx  (rd_idx),
        .rdata (mem_rdata)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and response outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (req_we && !addr_oor) ? WRESP : WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) state_nxt = BURST;
            end
            BURST: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_last  = err_q || (beat == BEAT_W'(BEATS_PER_LINE - 1));
                rsp_data  = err_q ? 32'd0 : mem_rdata;
                if (rsp_ready && rsp_last) state_nxt = IDLE;
            end
            WRESP: begin
                rsp_valid = 1'b1;
                rsp_last  = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // latency countdown, beat index and error flag for the active transaction
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lat_cnt <= '0;
            beat    <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            lat_cnt <= CNT_W'(LATENCY - 1);
            beat    <= '0;
            err_q   <= addr_oor;
        end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_W'(1);
        end else if (state == BURST && rsp_ready && !rsp_last) begin
            beat <= beat + BEAT_W'(1);
        end
    end

    // registered word index; low bits wrap so the burst stays inside the line
    always_ff @(posedge CLK) begin
        if (accept) begin
            rd_idx <= req_addr[AW-1:2];
        end else if (state == BURST && rsp_ready) begin
            rd_idx[1:0] <= rd_idx[1:0] + 2'd1;
        end
    end

endmodule

// File: tb/tb_imem_bus_responder.sv
// Bench for imem_bus_responder: a byte-level reference memory produces the
// expected beats into a queue as requests are issued; beats observed on the
// response port are collected and compared against that queue.
module tb_imem_bus_responder;

    localparam int MEMB = 1024;
    localparam int LAT  = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;

    imem_bus_responder #(
        .MEM_BYTES (MEMB),
        .LATENCY   (LAT)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         acc_cyc  = 0;
    logic [7:0] ref_mem [MEMB];
    beat_t      exp_q [$];
    beat_t      got_q [$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // expected beats of a read of address a
    task automatic exp_read(input logic [63:0] a);
        beat_t b;
        if (a >= 64'(MEMB)) begin
            b.data = '0; b.last = 1'b1; b.err = 1'b1;
            exp_q.push_back(b);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            int w = (int'(a[9:0]) & 'h3F0) + 4 * ((int'(a[3:2]) + k) % 4);
            b.data = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
            b.last = (k == 3);
            b.err  = 1'b0;
            exp_q.push_back(b);
        end
    endtask

    // update the reference memory and queue the single write-response beat
    task automatic exp_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
        beat_t b;
        b.data = '0; b.last = 1'b1; b.err = 1'b0;
        if (a >= 64'(MEMB)) b.err = 1'b1;
        else begin
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[(int'(a[9:0]) & 'h3FC) + i] = d[8*i +: 8];
        end
        exp_q.push_back(b);
    endtask

    // present a request until accepted; returns just after the accept edge
    task automatic issue(input logic [63:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
        int n = 0;
        req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_wstrb = ws;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tick();
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_we    = 1'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    // gather handshaken beats into got_q until it holds n_total (bounded);
    // first_lat = edges between accept and the first visible rsp_valid
    task automatic collect(input int n_total, output int first_lat);
        beat_t b;
        first_lat = -1;
        for (int c = 0; c < 40 && got_q.size() < n_total; c++) begin
            if (rsp_valid === 1'b1) begin
                if (first_lat < 0) first_lat = cyc - acc_cyc;
                if (rsp_ready === 1'b1) begin
                    b.data = rsp_data; b.last = rsp_last; b.err = rsp_err;
                    got_q.push_back(b);
                end
            end
            tick();
        end
    endtask

    // fetch observed beat i (all-x if missing) and the next expected beat
    task automatic pair(input int i, output beat_t g, output beat_t e);
        g = (i < got_q.size()) ? got_q[i] : 'x;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_addr = '0; req_we = 1'b0; req_wdata = '0; req_wstrb = '0;
        tick(); tick();
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b need=1", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b need=0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_last !== 1'b0) $display("FAIL rst_rsp_last got=%b need=0", rsp_last); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got=%b need=0", rsp_err); else n_pass++;
        n_checks++; if (rsp_data !== 32'd0) $display("FAIL rst_rsp_data got=%h need=0", rsp_data); else n_pass++;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        logic [63:0] wa [4] = '{64'h0, 64'h4, 64'h8, 64'hF};
        logic [31:0] wd [4] = '{32'h00508093, 32'h11223344, 32'hCAFEBABE, 32'hDEADBEEF};
        int lat;
        beat_t g, e;
        for (int j = 0; j < 4; j++) begin
            exp_q.delete(); got_q.delete();
            exp_write(wa[j], wd[j], 4'hF);
            issue(wa[j], 1'b1, wd[j], 4'hF);
            collect(1, lat);
            // write response is visible in the cycle right after the accept edge
            n_checks++; if (lat !== 0) $display("FAIL wr_latency[%0d] got=%0d need=0", j, lat); else n_pass++;
            pair(0, g, e);
            n_checks++;
            if (g !== e) $display("FAIL wr_beat[%0d] got %h/%b/%b need %h/%b/%b", j, g.data, g.last, g.err, e.data, e.last, e.err);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete();
        exp_read(64'h0);
        issue(64'h0, 1'b0, '0, '0);
        collect(4, lat);
        n_checks++; if (lat !== LAT) $display("FAIL rd_latency got=%0d need=%0d", lat, LAT); else n_pass++;
        n_checks++;
        if (got_q.size() > 0 && got_q[0].data !== 32'h00508093) $display("FAIL rd_word0 got=%h need=00508093", got_q[0].data);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pair(i, g, e);
            n_checks++;
            if (g !== e) $display("FAIL rd_beat[%0d] got %h/%b/%b need %h/%b/%b", i, g.data, g.last, g.err, e.data, e.last, e.err);
            else n_pass++;
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rd_idle_after got valid=%b ready=%b need 0/1", rsp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [63:0] ra [2] = '{64'h8, 64'h6};
        int lat;
        beat_t g, e;
        for (int j = 0; j < 2; j++) begin
            exp_q.delete(); got_q.delete();
            exp_read(ra[j]);
            issue(ra[j], 1'b0, '0, '0);
            collect(4, lat);
            n_checks++; if (lat !== LAT) $display("FAIL wrap_latency[%0d] got=%0d need=%0d", j, lat, LAT); else n_pass++;
            for (int i = 0; i < 4; i++) begin
                pair(i, g, e);
                n_checks++;
                if (g !== e) $display("FAIL wrap_beat[%0d.%0d] got %h/%b/%b need %h/%b/%b", j, i, g.data, g.last, g.err, e.data, e.last, e.err);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        beat_t g, e;
        exp_q.delete(); got_q.delete();
        exp_read(64'h0);
        issue(64'h0, 1'b0, '0, '0);
        rsp_ready = 1'b1;
        collect(1, lat);
        // second beat is now on the port; refuse it for five cycles
        rsp_ready = 1'b0;
        e = exp_q[1];
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || {rsp_data, rsp_last, rsp_err} !== e)
                $display("FAIL stall_hold[%0d] got v=%b %h/%b/%b need v=1 %h/%b/%b", c, rsp_valid, rsp_data, rsp_last, rsp_err, e.data, e.last, e.err);
            else n_pass++;
            tick();
        end
        rsp_ready = 1'b1;
        collect(4, lat);
        for (int i = 0; i < 4; i++) begin
            pair(i, g, e);
            n_checks++;
            if (g !== e) $display("FAIL stall_beat[%0d] got %h/%b/%b need %h/%b/%b", i, g.data, g.last, g.err, e.data, e.last, e.err);
            else n_pass++;
        end
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL stall_extra_beat got valid=%b need 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [63:0] oa [3] = '{64'h400, 64'h400, 64'h8000_0000_0000_0000};
        logic        ow [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        beat_t g, e;
        for (int j = 0; j < 3; j++) begin
            exp_q.delete(); got_q.delete();
            if (ow[j]) exp_write(oa[j], 32'hFFFFFFFF, 4'hF);
            else       exp_read(oa[j]);
            issue(oa[j], ow[j], 32'hFFFFFFFF, 4'hF);
            collect(1, lat);
            n_checks++; if (lat !== LAT) $display("FAIL oor_latency[%0d] got=%0d need=%0d", j, lat, LAT); else n_pass++;
            pair(0, g, e);
            n_checks++;
            if (g !== e) $display("FAIL oor_beat[%0d] got %h/%b/%b need %h/%b/%b", j, g.data, g.last, g.err, e.data, e.last, e.err);
            else n_pass++;
            n_checks++;
            if (rsp_valid !== 1'b0) $display("FAIL oor_single_beat[%0d] got valid=%b need 0", j, rsp_valid); else n_pass++;
        end
        // line 0 must be untouched by the out-of-range write
        exp_q.delete(); got_q.delete();
        exp_read(64'h0);
        issue(64'h0, 1'b0, '0, '0);
        collect(4, lat);
        for (int i = 0; i < 4; i++) begin
            pair(i, g, e);
            n_checks++;
            if (g !== e) $display("FAIL oor_mem_kept[%0d] got %h need %h", i, g.data, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_strobe();
        int lat;
        beat_t g, e;
        exp_q.delete(); got_q.delete();
        exp_write(64'h4, 32'hAABBCCDD, 4'h2);
        issue(64'h4, 1'b1, 32'hAABBCCDD, 4'h2);
        collect(1, lat);
        exp_write(64'h8, 32'h55555555, 4'h0);
        issue(64'h8, 1'b1, 32'h55555555, 4'h0);
        collect(2, lat);
        for (int i = 0; i < 2; i++) begin
            pair(i, g, e);
            n_checks++;
            if (g !== e) $display("FAIL strb_wresp[%0d] got %h/%b/%b need %h/%b/%b", i, g.data, g.last, g.err, e.data, e.last, e.err);
            else n_pass++;
        end
        exp_q.delete(); got_q.delete();
        exp_read(64'h4);
        issue(64'h4, 1'b0, '0, '0);
        collect(4, lat);
        n_checks++;
        if (got_q.size() < 2 || got_q[0].data !== 32'h1122CC44 || got_q[1].data !== 32'hCAFEBABE)
            $display("FAIL strb_words got %h,%h need 1122cc44,cafebabe",
                     (got_q.size() > 0) ? got_q[0].data : 32'hx, (got_q.size() > 1) ? got_q[1].data : 32'hx);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pair(i, g, e);
            n_checks++;
            if (g !== e) $display("FAIL strb_read[%0d] got %h/%b/%b need %h/%b/%b", i, g.data, g.last, g.err, e.data, e.last, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        beat_t g, e;
        exp_q.delete(); got_q.delete();
        exp_read(64'h0);
        issue(64'h0, 1'b0, '0, '0);
        collect(1, lat);
        RESET = 1'b1;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_burst_valid got=%b need=0", rsp_valid); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_burst_ready got=%b need=1", req_ready); else n_pass++;
        RESET = 1'b0;
        // abort during the latency wait
        issue(64'h8, 1'b0, '0, '0);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid !== 1'b0) seen++;
            tick();
        end
        n_checks++; if (seen != 0) $display("FAIL rst_wait_beats got=%0d need=0", seen); else n_pass++;
        exp_q.delete(); got_q.delete();
        exp_read(64'h8);
        issue(64'h8, 1'b0, '0, '0);
        collect(4, lat);
        n_checks++; if (lat !== LAT) $display("FAIL rst_after_latency got=%0d need=%0d", lat, LAT); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pair(i, g, e);
            n_checks++;
            if (g !== e) $display("FAIL rst_after_beat[%0d] got %h/%b/%b need %h/%b/%b", i, g.data, g.last, g.err, e.data, e.last, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        beat_t g, e;
        exp_q.delete(); got_q.delete();
        exp_read(64'h0);
        exp_read(64'h0);
        issue(64'h0, 1'b0, '0, '0);
        // a write held on the request port during the burst must be ignored
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h0; req_wdata = 32'h0; req_wstrb = 4'hF;
        collect(3, lat);
        req_valid = 1'b0;
        collect(4, lat);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL b2b_ready got=%b need=1", req_ready); else n_pass++;
        issue(64'h0, 1'b0, '0, '0);
        collect(8, lat);
        n_checks++; if (lat !== LAT) $display("FAIL b2b_latency got=%0d need=%0d", lat, LAT); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            pair(i, g, e);
            n_checks++;
            if (g !== e) $display("FAIL b2b_beat[%0d] got %h/%b/%b need %h/%b/%b", i, g.data, g.last, g.err, e.data, e.last, e.err);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_stall();
        test_out_of_range();
        test_strobe();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
